// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_unit_pkg : funct3 codes, FSM states and helpers for muldiv_unit
// Revision 1.0
// ---------------------------------------------------------------------------
package muldiv_unit_pkg;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // Two's-complement negate when n is set (magnitude / sign restore)
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_unit : iterative RV32M multiply/divide, one bit per cycle, fixed
//               latency of XLEN iterations.
// Revision 1.0
// ---------------------------------------------------------------------------
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_e     r_state, w_state_next;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc, w_acc_next, w_prod;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_res, r_neg_rem, r_div0, r_ovf;
  logic [XLEN-1:0]   r_result, w_result_final;

  logic              w_accept, w_last;
  logic              w_a_signed, w_b_signed, w_sgn_a, w_sgn_b;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic [XLEN:0]     w_mul_sum, w_div_rem;
  logic [XLEN-1:0]   w_div_diff, w_quo, w_rem;
  logic              w_div_ge;

  assign w_accept = start && (r_state != ST_RUN);
  assign w_last   = (r_cnt == CNT_W'(1));

  assign w_a_signed = (op == MULDIV_MUL) || (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
                      (op == MULDIV_DIV) || (op == MULDIV_REM);
  assign w_b_signed = (op == MULDIV_MUL) || (op == MULDIV_MULH) ||
                      (op == MULDIV_DIV) || (op == MULDIV_REM);
  assign w_sgn_a = w_a_signed & a[XLEN-1];
  assign w_sgn_b = w_b_signed & b[XLEN-1];
  assign w_mag_a = neg_if(a, w_sgn_a);
  assign w_mag_b = neg_if(b, w_sgn_b);

  // Multiply: multiplier sits in acc low half and shifts out LSB-first.
  // Divide: dividend shifts out of acc low half into the partial remainder.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
    w_div_rem  = r_acc[2*XLEN-1:XLEN-1];
    w_div_ge   = (w_div_rem >= {1'b0, r_opnd});
    w_div_diff = w_div_rem[XLEN-1:0] - r_opnd;
    if (r_op[2]) begin
      w_acc_next = {(w_div_ge ? w_div_diff : w_div_rem[XLEN-1:0]), r_acc[XLEN-2:0], w_div_ge};
    end else begin
      w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
    end
  end

  always_comb begin
    w_prod = r_neg_res ? (~w_acc_next + 1'b1) : w_acc_next;
    w_quo  = neg_if(w_acc_next[XLEN-1:0], r_neg_res);
    w_rem  = neg_if(w_acc_next[2*XLEN-1:XLEN], r_neg_rem);
    case (r_op)
      MULDIV_MUL:                 w_result_final = w_prod[XLEN-1:0];
      MULDIV_DIV, MULDIV_DIVU:    w_result_final = r_div0 ? '1 :
                                                   r_ovf  ? {1'b1, {(XLEN-1){1'b0}}} : w_quo;
      // b==0 remainder falls out as the dividend after sign restore
      MULDIV_REM, MULDIV_REMU:    w_result_final = r_ovf ? '0 : w_rem;
      default:                    w_result_final = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_op      <= op;
      r_cnt     <= CNT_W'(XLEN);
      r_neg_res <= w_sgn_a ^ w_sgn_b;
      r_neg_rem <= w_sgn_a;
      r_div0    <= (b == '0);
      r_ovf     <= ((op == MULDIV_DIV) || (op == MULDIV_REM)) &&
                   (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
      if (op[2]) begin
        r_opnd <= w_mag_b;
        r_acc  <= {{XLEN{1'b0}}, w_mag_a};
      end else begin
        r_opnd <= w_mag_a;
        r_acc  <= {{XLEN{1'b0}}, w_mag_b};
      end
    end else if (r_state == ST_RUN) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - 1'b1;
      if (w_last) r_result <= w_result_final;
    end
  end

  assign busy   = (r_state == ST_RUN);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muldiv_unit : scoreboard bench for muldiv_unit
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk, rst_n, start, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  typedef struct {
    logic [31:0] exp;
    int          c0;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  logic [31:0] last_result = '0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [63:0] sx, sy, ux, uy, p;
    logic        ovf;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ux  = {32'b0, x};
    uy  = {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    model = '0;
    case (f)
      MULDIV_MUL:    begin p = sx * sy; model = p[31:0];  end
      MULDIV_MULH:   begin p = sx * sy; model = p[63:32]; end
      MULDIV_MULHSU: begin p = sx * uy; model = p[63:32]; end
      MULDIV_MULHU:  begin p = ux * uy; model = p[63:32]; end
      MULDIV_DIV:    model = (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 :
                             32'($signed(x) / $signed(y));
      MULDIV_REM:    model = (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
      MULDIV_DIVU:   model = (y == 0) ? 32'hFFFF_FFFF : x / y;
      default:       model = (y == 0) ? x : x % y;
    endcase
  endfunction

  // Monitor: pops the scoreboard on done, checks latency, busy length and hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        check_value("result_hold", result, last_result);
      end
      if (done) begin
        check_value("busy_done_excl", {31'b0, busy}, 32'h0);
        check_value("busy_len", busy_cnt, 32'd32);
        busy_cnt = 0;
        if (sb_q.size() == 0) begin
          check_value("spurious_done", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_value("result", result, e.exp);
          check_value("latency", cyc - e.c0, 32'd33);
          last_result = e.exp;
        end
      end
    end
  end

  // Call at a negedge; drives start for one cycle.
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp);
    exp_t e;
    e.exp = exp;
    e.c0  = cyc;
    sb_q.push_back(e);
    start = 1'b1; op = f; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = $urandom_range(7, 0); a = $urandom; b = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_value("timeout", sb_q.size(), 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x, y, exp;
  } vec_t;

  vec_t vecs[$] = '{
    '{MULDIV_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{MULDIV_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{MULDIV_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{MULDIV_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{MULDIV_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
    '{MULDIV_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
    '{MULDIV_DIVU,   32'd100,       32'd7,         32'd14},
    '{MULDIV_REMU,   32'd100,       32'd7,         32'd2},
    '{MULDIV_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF},
    '{MULDIV_REMU,   32'd5,         32'd0,         32'd5},
    '{MULDIV_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{MULDIV_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0}
  };

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_value("rst_busy", {31'b0, busy}, 32'h0);
    check_value("rst_done", {31'b0, done}, 32'h0);
    check_value("rst_result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].exp);
      wait_idle();
    end

    for (int i = 0; i < 16; i++) begin
      logic [2:0]  f;
      logic [31:0] x, y;
      f = $urandom_range(7, 0);
      x = $urandom;
      y = (i % 5 == 0) ? 32'h0 : (i % 3 == 0) ? ($urandom & 32'hFF) : $urandom;
      issue(f, x, y, model(f, x, y));
      wait_idle();
    end

    // start mid-RUN is ignored
    issue(MULDIV_MUL, 32'd1234, 32'd5678, 32'd7006652);
    repeat (5) @(negedge clk);
    start = 1'b1; op = MULDIV_DIVU; a = 32'd99; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // back-to-back: start in the DONE cycle
    issue(MULDIV_DIVU, 32'd1000, 32'd9, 32'd111);
    begin
      int n = 0;
      while (!done && n < 100) begin @(negedge clk); n++; end
      check_value("b2b_done_seen", {31'b0, done}, 32'h1);
    end
    issue(MULDIV_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    check_value("b2b_busy", {31'b0, busy}, 32'h1);
    wait_idle();

    // asynchronous reset mid-operation
    issue(MULDIV_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_value("amid_busy", {31'b0, busy}, 32'h0);
    check_value("amid_done", {31'b0, done}, 32'h0);
    check_value("amid_result", result, 32'h0);
    sb_q.delete();
    last_result = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(MULDIV_MUL, 32'd3, 32'd4, 32'd12);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the execute stage. It sits beside the ALU, takes the same a/b operand buses, and feeds its result into the execute result mux in place of the ALU result. It computes one bit per cycle with a fixed latency. The control FSM holds the instruction (stall) while busy is high.

Parameters:
XLEN, 32, operand and result width; only 32 is supported.
CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
clk  input  1  core clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request pulse; accepted only in IDLE or DONE
op  input  3  funct3 encoding: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111
a  input  XLEN  rs1 operand, sampled only on an accepted start
b  input  XLEN  rs2 operand, sampled only on an accepted start
busy  output  1  high while the operation is in flight (RUN state)
done  output  1  single-cycle pulse; result is valid in this cycle
result  output  XLEN  registered result; held until the next accepted start completes

Behaviour:
- Reset (async, rst_n low):
  - state goes to IDLE; busy=0, done=0, result=0, counter=0; all internal registers cleared.
  - Reset mid-operation abandons the operation with no done pulse.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch op, |a|, |b| (absolute values per signedness), the sign flags and the special-case flags; counter=XLEN; go to RUN.
  - RUN: one iteration per cycle, counter decrements; at counter==1 go to DONE and register the final, sign-corrected result.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back) -> RUN. Otherwise go to IDLE.
- start is ignored in RUN. Operands are never re-sampled during RUN.
- Latency: start sampled at edge E0; busy is high for cycles E0+1..E0+32; done is high in cycle E0+33. Latency is fixed for every op, including the special cases.
- busy and done are never both high.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Multiply:
  - Radix-2 shift-add on magnitudes into a 64-bit product.
  - Negate the product if the operand signs differ.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Restoring division on magnitudes.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
- Special cases (flags latched at start, applied at the final cycle):
  - b==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- result changes only on the transition RUN->DONE.

Decomposition:
- The MULDIV_* funct3 codes and the state encodings belong in the shared constants include file, alongside the ALU op constants.
- A single module is sufficient. The shared shift/accumulate datapath (64-bit accumulator plus 32-bit operand register) stays inline; no sub-module.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD (-3) -> result=0xFFFFFFEB; done high exactly 33 cycles after the start edge; busy high 32 cycles.
2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. All with 33-cycle latency.
5. start pulsed with new operands mid-RUN -> ignored, original result returned. start asserted in the DONE cycle -> busy high on the next cycle, second result correct.
6. rst_n low 10 cycles after start -> busy, done and result go to 0 immediately with no done pulse. After release, a new MUL 3*4 returns 12.
